mat_alu_sched: RTL

Two-requester scheduler for the shared 3x3 matrix ALU (transpose, add, subtract, scalar multiply, determinant). It arbitrates between two clients and latches the winning operation. It holds the ALU operands stable for the operation's latency, then captures the result into a response register with valid/ready handshake. It sits between the clients and the single matrix ALU instance, driving every ALU input port.

---
 rtl/mat_alu_sched.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mat_alu_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mat_alu_sched
//  Purpose  : Two-requester scheduler in front of the shared 3x3 matrix ALU.
//             Arbitrates between two clients, latches the winning operation
//             into holding registers that drive every ALU input, waits out
//             the ALU latency, captures the result and presents it on a
//             valid/ready response port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    OP_LAT   cycles the ALU needs for sel 0-3 (transpose/add/sub/scale)
//    DET_LAT  cycles the ALU needs for sel 4-7 (determinant pipeline)
//  Build option
//    MATSCHED_FIXED_PRIO_EN  defined   : req0 always beats req1, no RR pointer
//                            undefined : round-robin between req0 and req1
//  Ports
//    clk          rising-edge clock
//    reset        asynchronous active-low reset
//    reqN         level request from client N (operands stable until gntN)
//    selN/cN      opcode / scalar of client N
//    aN/bN        matrix operands, E00 at [287:256] ... E22 at [31:0]
//    gntN         one-cycle pulse when client N's operation is latched
//    alu_sel/c/a/b  held ALU operands (hold last value while idle)
//    alu_mat/det  ALU results
//    rsp_valid/ready  response handshake
//    rsp_id       client index of the response
//    rsp_mat/det  captured results (the unused one is forced to zero)
//    busy         high whenever the scheduler is not idle
// ============================================================================
module mat_alu_sched #(
    parameter int OP_LAT  = 1,
    parameter int DET_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0,
    input  logic [2:0]   sel0,
    input  logic [31:0]  c0,
    input  logic [287:0] a0,
    input  logic [287:0] b0,
    output logic         gnt0,

    input  logic         req1,
    input  logic [2:0]   sel1,
    input  logic [31:0]  c1,
    input  logic [287:0] a1,
    input  logic [287:0] b1,
    output logic         gnt1,

    output logic [2:0]   alu_sel,
    output logic [31:0]  alu_c,
    output logic [287:0] alu_a,
    output logic [287:0] alu_b,
    input  logic [287:0] alu_mat,
    input  logic [31:0]  alu_det,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [287:0] rsp_mat,
    output logic [31:0]  rsp_det,

    output logic         busy
);

    // ------------------------------------------------------------------------
    // Latency counter sizing
    // ------------------------------------------------------------------------
    localparam int c_MAX_LAT = (OP_LAT > DET_LAT) ? OP_LAT : DET_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_OP_CNT  = c_CNT_W'(OP_LAT);
    localparam logic [c_CNT_W-1:0] c_DET_CNT = c_CNT_W'(DET_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_CNT_W-1:0]   r_lat_cnt;
    logic                 r_winner;     // client owning the in-flight op

    logic                 w_any_req;
    logic                 w_win;        // 0 = req0 wins, 1 = req1 wins
    logic                 w_grant;
    logic                 w_capture;

    logic [2:0]           w_win_sel;
    logic [31:0]          w_win_c;
    logic [287:0]         w_win_a;
    logic [287:0]         w_win_b;

    assign w_any_req = req0 | req1;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef MATSCHED_FIXED_PRIO_EN
    // req0 wins whenever it is present.
    always_comb begin
        w_win = ~req0;
    end
`else
    // r_last remembers the last granted client; on a tie the other client
    // wins. Reset value 1 makes req0 the favoured client after reset.
    logic r_last;

    always_comb begin
        if (req0 && req1) begin
            w_win = ~r_last;
        end else begin
            w_win = req1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`endif

    // Operand mux for the winning client.
    always_comb begin
        if (w_win) begin
            w_win_sel = sel1;
            w_win_c   = c1;
            w_win_a   = a1;
            w_win_b   = b1;
        end else begin
            w_win_sel = sel0;
            w_win_c   = c0;
            w_win_a   = a0;
            w_win_b   = b0;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Requests are only ever sampled here; a request dropped
                // before this point simply never wins.
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_lat_cnt == c_CNT_ONE) begin
                    w_state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant pulses, holding registers and latency counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            alu_sel   <= '0;
            alu_c     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            r_winner  <= 1'b0;
            r_lat_cnt <= '0;
        end else begin
            gnt0 <= w_grant & ~w_win;
            gnt1 <= w_grant &  w_win;
            if (w_grant) begin
                alu_sel   <= w_win_sel;
                alu_c     <= w_win_c;
                alu_a     <= w_win_a;
                alu_b     <= w_win_b;
                r_winner  <= w_win;
                // sel[2] distinguishes the determinant opcodes (4-7).
                r_lat_cnt <= w_win_sel[2] ? c_DET_CNT : c_OP_CNT;
            end else if (r_state == S_EXEC) begin
                r_lat_cnt <= r_lat_cnt - c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response capture; only the result class matching the opcode is kept
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_id  <= 1'b0;
            rsp_mat <= '0;
            rsp_det <= '0;
        end else if (w_capture) begin
            rsp_id <= r_winner;
            if (alu_sel[2]) begin
                rsp_mat <= '0;
                rsp_det <= alu_det;
            end else begin
                rsp_mat <= alu_mat;
                rsp_det <= '0;
            end
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
